// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: word-addressed data-memory request/ready port
//   master: load/store unit (drives req, we, addr, be, wdata; samples rdata, ready)
//   slave : data memory    (drives rdata, ready)
interface mem_access_unit_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ready;
  modport master(output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, input dmem_rdata, dmem_ready);
  modport slave(input dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, output dmem_rdata, dmem_ready);
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store unit with request/ready memory handshake
//   clk, reset_n           : clock, async active-low reset
//   MEM_cntl_MemRead/Write : access type (write wins when both are set)
//   MEM_funct              : width code B/H/W/BU/HU
//   MEM_ALUResult          : byte address; MEM_WriteMemData: store source
//   dmem                   : memory port (master side)
//   mem_stall              : freezes upstream pipeline while an access is in flight
//   MEM_ReadData           : extended load result, held until the next load completes
//   misalign_err           : one-cycle pulse for a dropped illegal/misaligned access
module mem_access_unit (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     MEM_cntl_MemRead,
  input  logic                     MEM_cntl_MemWrite,
  input  logic [2:0]               MEM_funct,
  input  logic [31:0]              MEM_ALUResult,
  input  logic [31:0]              MEM_WriteMemData,
  mem_access_unit_if.master        dmem,
  output logic                     mem_stall,
  output logic [31:0]              MEM_ReadData,
  output logic                     misalign_err
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t      r_state;
  logic        r_req, r_we, r_mis;
  logic [31:0] r_addr, r_wdata, r_rd;
  logic [3:0]  r_be;
  logic [2:0]  r_funct;
  logic [1:0]  r_lane;
  logic        w_access, w_legal;
  logic [1:0]  w_a;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_ext;
  logic [15:0] w_half;
  logic [7:0]  w_byte;
  assign w_a      = MEM_ALUResult[1:0];
  assign w_access = MEM_cntl_MemRead | MEM_cntl_MemWrite;
  // BU/HU exist only for loads; a store with 1xx is dropped as illegal
  assign w_legal  = (MEM_funct == 3'b000)
                  | (MEM_funct == 3'b001 && !w_a[0])
                  | (MEM_funct == 3'b010 && w_a == 2'b00)
                  | (!MEM_cntl_MemWrite && (MEM_funct == 3'b100 || (MEM_funct == 3'b101 && !w_a[0])));
  assign w_be     = (!MEM_cntl_MemWrite || MEM_funct[1]) ? 4'hf
                  : MEM_funct[0] ? (w_a[1] ? 4'hc : 4'h3)
                  : 4'b0001 << w_a;
  assign w_wdata  = MEM_funct[1] ? MEM_WriteMemData
                  : MEM_funct[0] ? {2{MEM_WriteMemData[15:0]}}
                  : {4{MEM_WriteMemData[7:0]}};
  // funct[2] marks the unsigned variants, so it gates the sign bit
  assign w_byte   = 8'(dmem.dmem_rdata >> {r_lane, 3'b000});
  assign w_half   = r_lane[1] ? dmem.dmem_rdata[31:16] : dmem.dmem_rdata[15:0];
  assign w_ext    = r_funct[1] ? dmem.dmem_rdata
                  : r_funct[0] ? {{16{~r_funct[2] & w_half[15]}}, w_half}
                  : {{24{~r_funct[2] & w_byte[7]}}, w_byte};
  assign mem_stall        = (r_state == IDLE && w_access && w_legal) || r_state == REQ;
  assign misalign_err     = r_mis;
  assign MEM_ReadData     = r_rd;
  assign dmem.dmem_req    = r_req;
  assign dmem.dmem_we     = r_we;
  assign dmem.dmem_addr   = r_addr;
  assign dmem.dmem_be     = r_be;
  assign dmem.dmem_wdata  = r_wdata;
  // DONE is a one-cycle guard so the instruction still held in EX/MEM is not re-issued
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_req   <= 1'b0;
      r_we    <= 1'b0;
      r_mis   <= 1'b0;
      r_addr  <= '0;
      r_be    <= '0;
      r_wdata <= '0;
      r_rd    <= '0;
      r_funct <= '0;
      r_lane  <= '0;
    end else begin
      r_mis <= 1'b0;
      case (r_state)
        IDLE: if (w_access && w_legal) begin
          r_state <= REQ;
          r_req   <= 1'b1;
          r_we    <= MEM_cntl_MemWrite;
          r_addr  <= {MEM_ALUResult[31:2], 2'b00};
          r_be    <= w_be;
          r_wdata <= w_wdata;
          r_funct <= MEM_funct;
          r_lane  <= w_a;
        end else r_mis <= w_access;
        REQ: if (dmem.dmem_ready) begin
          r_state <= DONE;
          r_req   <= 1'b0;
          if (!r_we) r_rd <= w_ext;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: scoreboard bench for mem_access_unit
module tb_mem_access_unit;
  logic        clk = 1'b0, reset_n = 1'b0, rd = 1'b0, wr = 1'b0;
  logic [2:0]  funct = '0;
  logic [31:0] addr = '0, wdat = '0;
  logic        stall, misalign;
  logic [31:0] rdout;
  logic [31:0] last_rd = '0;
  int          checks = 0, errors = 0;
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
  } exp_t;
  exp_t sb[$];
  mem_access_unit_if bus();
  mem_access_unit dut (
    .clk(clk),
    .reset_n(reset_n),
    .MEM_cntl_MemRead(rd),
    .MEM_cntl_MemWrite(wr),
    .MEM_funct(funct),
    .MEM_ALUResult(addr),
    .MEM_WriteMemData(wdat),
    .dmem(bus),
    .mem_stall(stall),
    .MEM_ReadData(rdout),
    .misalign_err(misalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic access(input logic ld, input logic [2:0] f, input logic [31:0] a, input logic [31:0] d,
                        input int waits, input logic [31:0] mem_word, input logic [3:0] be,
                        input logic [31:0] wd, input logic [31:0] rdv);
    exp_t e;
    int n_stall = 0;
    e.we = !ld;
    e.addr = {a[31:2], 2'b00};
    e.be = be;
    e.wdata = wd;
    e.rd = ld ? rdv : last_rd;
    sb.push_back(e);
    rd = ld; wr = !ld; funct = f; addr = a; wdat = d; bus.dmem_ready = 1'b0;
    #1;
    chk("stall_c0", stall, 1);
    n_stall += int'(stall);
    for (int k = 0; k <= waits; k++) begin
      @(posedge clk); #1;
      n_stall += int'(stall);
      chk("req", bus.dmem_req, 1);
      chk("we", bus.dmem_we, sb[0].we);
      chk("addr", bus.dmem_addr, sb[0].addr);
      chk("be", bus.dmem_be, sb[0].be);
      if (!ld) chk("wdata", bus.dmem_wdata, sb[0].wdata);
      if (k == waits) begin
        bus.dmem_ready = 1'b1;
        bus.dmem_rdata = mem_word;
      end
    end
    @(posedge clk); #1;
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = $urandom();
    n_stall += int'(stall);
    chk("done_req", bus.dmem_req, 0);
    chk("done_stall", stall, 0);
    e = sb.pop_front();
    chk("rdata", rdout, e.rd);
    last_rd = e.rd;
    rd = 1'b0; wr = 1'b0;
    chk("stall_cycles", n_stall, waits + 2);
    @(posedge clk); #1;
    chk("idle_req", bus.dmem_req, 0);
    chk("rdata_hold", rdout, last_rd);
  endtask
  task automatic bad(input logic ld, input logic [2:0] f, input logic [31:0] a);
    rd = ld; wr = !ld; funct = f; addr = a; wdat = 32'h5555AAAA;
    #1;
    chk("bad_stall0", stall, 0);
    chk("bad_err0", misalign, 0);
    @(posedge clk); #1;
    chk("bad_err", misalign, 1);
    chk("bad_req", bus.dmem_req, 0);
    chk("bad_stall", stall, 0);
    rd = 1'b0; wr = 1'b0;
    @(posedge clk); #1;
    chk("bad_pulse", misalign, 0);
    chk("bad_req2", bus.dmem_req, 0);
    chk("bad_rdata", rdout, last_rd);
  endtask
  initial begin
    bus.dmem_ready = 1'b0;
    bus.dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", bus.dmem_req, 0);
    chk("rst_we", bus.dmem_we, 0);
    chk("rst_addr", bus.dmem_addr, 0);
    chk("rst_be", bus.dmem_be, 0);
    chk("rst_wdata", bus.dmem_wdata, 0);
    chk("rst_rdata", rdout, 0);
    chk("rst_err", misalign, 0);
    chk("rst_stall", stall, 0);
    reset_n = 1'b1;
    @(posedge clk); #1;
    access(1, 3'b010, 32'h100, 0, 2, 32'hDEADBEEF, 4'hf, 0, 32'hDEADBEEF);
    access(1, 3'b000, 32'h203, 0, 0, 32'h80FF0000, 4'hf, 0, 32'hFFFFFF80);
    access(1, 3'b100, 32'h203, 0, 1, 32'h80FF0000, 4'hf, 0, 32'h00000080);
    access(1, 3'b001, 32'h202, 0, 0, 32'h80FF0000, 4'hf, 0, 32'hFFFF80FF);
    access(1, 3'b101, 32'h200, 0, 1, 32'h1234ABCD, 4'hf, 0, 32'h0000ABCD);
    access(1, 3'b001, 32'h200, 0, 0, 32'h1234ABCD, 4'hf, 0, 32'hFFFFABCD);
    access(1, 3'b000, 32'h201, 0, 0, 32'h00007F00, 4'hf, 0, 32'h0000007F);
    access(0, 3'b000, 32'h005, 32'h123456AB, 0, 0, 4'b0010, 32'hABABABAB, 0);
    access(0, 3'b001, 32'h006, 32'h123456AB, 1, 0, 4'b1100, 32'h56AB56AB, 0);
    access(0, 3'b001, 32'h004, 32'h123456AB, 0, 0, 4'b0011, 32'h56AB56AB, 0);
    access(0, 3'b000, 32'h00B, 32'h000000C3, 0, 0, 4'b1000, 32'hC3C3C3C3, 0);
    access(0, 3'b010, 32'h010, 32'hCAFEF00D, 5, 0, 4'hf, 32'hCAFEF00D, 0);
    bad(1, 3'b010, 32'h102);
    bad(0, 3'b001, 32'h001);
    bad(0, 3'b100, 32'h008);
    bad(0, 3'b101, 32'h008);
    bad(1, 3'b011, 32'h000);
    bad(1, 3'b101, 32'h003);
    rd = 1'b1; wr = 1'b0; funct = 3'b010; addr = 32'h300; bus.dmem_ready = 1'b0;
    @(posedge clk); #1;
    chk("mid_req", bus.dmem_req, 1);
    @(posedge clk); #2;
    reset_n = 1'b0;
    rd = 1'b0;
    #1;
    chk("arst_req", bus.dmem_req, 0);
    chk("arst_rdata", rdout, 0);
    chk("arst_stall", stall, 0);
    last_rd = '0;
    @(posedge clk); #1;
    reset_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_req", bus.dmem_req, 0);
    access(1, 3'b010, 32'h300, 0, 1, 32'h0BADF00D, 4'hf, 0, 32'h0BADF00D);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

MEM-stage load/store unit placed directly downstream of the EX/MEM pipeline register. It consumes the registered MEM-stage control, address (ALU result), store data and funct fields, and runs a request/ready transaction on the data-memory port. It aligns store data and generates byte enables, and it sign- or zero-extends load data for write-back. While a transaction is outstanding it asserts a stall to freeze the upstream pipeline.

## Interface
Parameters:
- none; all data paths are 32-bit and the memory port is word-addressed.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge
- reset_n  in  1  asynchronous, active-low reset
- MEM_cntl_MemRead  in  1  load in MEM stage
- MEM_cntl_MemWrite  in  1  store in MEM stage; takes priority if both are high
- MEM_funct  in  3  width code: 000 B, 001 H, 010 W, 100 BU, 101 HU (the last two are loads only)
- MEM_ALUResult  in  32  effective byte address
- MEM_WriteMemData  in  32  store source register value
- dmem_req  out  1  transaction request (registered)
- dmem_we  out  1  1 = write
- dmem_addr  out  32  {addr[31:2], 2'b00}
- dmem_be  out  4  byte enables, bit i = byte lane i
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read word, valid when dmem_ready = 1
- dmem_ready  in  1  completes the current request
- mem_stall  out  1  freeze PC, IF/ID, ID/EX, EX/MEM
- MEM_ReadData  out  32  extended load result; holds its value until the next load completes
- misalign_err  out  1  one-cycle pulse for a dropped illegal or misaligned access

## Operation
- State machine: IDLE, REQ, DONE.
- **IDLE:**
  - access = MemRead | MemWrite.
  - legal = funct/size valid and aligned:
    - H/HU require addr[0] = 0.
    - W requires addr[1:0] = 0.
    - 011, 110 and 111 are illegal, as are stores with 100 or 101.
  - access & legal: latch we, address, be, wdata, funct and addr[1:0], then go to REQ.
  - access & !legal: no request; misalign_err = 1 on the next cycle; stay in IDLE.
- **REQ:**
  - dmem_req = 1, and all dmem_* outputs are held stable until dmem_ready.
  - On dmem_ready: if load, capture the extended dmem_rdata into MEM_ReadData; go to DONE.
- **DONE:** dmem_req = 0; no new request may start; go to IDLE unconditionally. This prevents the same instruction from being re-issued while EX/MEM reloads.
- **mem_stall:** combinational; = (IDLE & access & legal) | REQ. It is 0 in DONE.
- **Store alignment:**
  - SB: be = 1 << addr[1:0]; wdata = {4{data[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{data[15:0]}}.
  - SW: be = 1111; wdata = data.
- **Loads:**
  - be = 1111.
  - Select the byte lane addr[1:0] or the half lane addr[1].
  - B and H sign-extend; BU and HU zero-extend; W passes through.
- **Reset values:**
  - State IDLE.
  - dmem_req, dmem_we and misalign_err = 0.
  - dmem_addr, dmem_be, dmem_wdata and MEM_ReadData = 0.
  - mem_stall = 0 (inputs are 0 after EX/MEM reset).
- **Reset mid-transaction:** dmem_req drops asynchronously and the transaction is abandoned. The memory side must tolerate this.

## Timing
- **Minimum access (ready already high):**
  - Cycle 0: IDLE, stall = 1.
  - Cycle 1: REQ, req = 1, ready = 1.
  - Cycle 2: DONE, stall = 0, MEM_ReadData valid.
  - The pipeline advances at the end of cycle 2.
- **Wait states:** each cycle with ready = 0 in REQ adds one cycle, and stall stays 1 throughout.
- **misalign_err:** asserted in the cycle after IDLE sees the bad access; stall is never asserted for it.
- **Back-to-back accesses:** the next access is sampled in the IDLE cycle after DONE, so there is no overlap.

## Test plan
- **LW:** addr 0x100, ready after 2 wait cycles, rdata 0xDEADBEEF.
  - Required: stall high for 4 cycles; dmem_addr 0x100; be 1111; MEM_ReadData 0xDEADBEEF in DONE.
- **LB / LBU:** addr 0x203, rdata 0x80FF_0000.
  - Required: LB gives 0xFFFFFF80; LBU gives 0x00000080.
  - Also LH at addr 0x202 gives 0xFFFF80FF.
- **SB:** addr 0x005, data 0x123456AB.
  - Required: dmem_addr 0x004; be 0010; wdata 0xABABABAB; we = 1.
  - Also SH at addr 0x006 gives be 1100 and wdata 0x56AB56AB.
- **Misaligned:** LW at addr 0x102, and SH at addr 0x001.
  - Required: no dmem_req; stall stays 0; misalign_err is a 1-cycle pulse.
- **Handshake stability:** ready held low for 5 cycles.
  - Required: req, addr, be and wdata constant; stall constant 1; no second request during DONE.
- **Reset mid-REQ:** reset_n dropped while in REQ.
  - Required: dmem_req and MEM_ReadData are 0 immediately.
  - After release, the unit is IDLE and a fresh LW completes normally.
